rob_ctrl: RTL and testbench

Reorder-buffer controller answering the decode stage's slot-reservation interface. It hands out up to four consecutive ROB slots per cycle and records each slot's destination register. It accepts out-of-order completions from two writeback ports and retires up to two entries per cycle in program order to the register file. It sits between decode (reservation side), the execution units (completion side) and the architectural register file (retire side).

---
 rtl/rob_ctrl_pkg.sv | 18 +
 rtl/rob_ctrl_if.sv | 38 +++
 rtl/rob_ctrl.sv | 121 ++++++++++++
 tb/tb_rob_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_ctrl_pkg.sv
// Shared types and widths for the reorder-buffer controller.
// One entry holds the destination register, completion flag and the result.
package rob_ctrl_pkg;

    localparam int ROB_RESERVE_WIDTH  = 4;
    localparam int ROB_RETIRE_WIDTH   = 2;
    localparam int ROB_COMPLETE_PORTS = 2;
    localparam int ROB_REG_W          = 5;
    localparam int ROB_DATA_W         = 32;

    typedef struct packed {
        logic [ROB_REG_W-1:0]  dest_reg;
        logic                  dest_reg_valid;
        logic                  done;
        logic [ROB_DATA_W-1:0] result;
    } rob_entry_t;

endpackage

// File: rtl/rob_ctrl_if.sv
// Decode, writeback and retire signals of the ROB controller.
// The slave modport is the ROB; the master modport is its surroundings.
interface rob_ctrl_if
    import rob_ctrl_pkg::*;
#(
    parameter int ROB_DEPTHLOG2 = 4
) ();

    logic                                              flush;
    logic                                              reserve;
    logic [1:0]                                        reserve_count;
    logic [ROB_RESERVE_WIDTH-1:0][ROB_REG_W-1:0]       dest_reg;
    logic [ROB_RESERVE_WIDTH-1:0]                      dest_reg_valid;
    logic [ROB_RESERVE_WIDTH-1:0][ROB_DEPTHLOG2-1:0]   reserved_slots;
    logic                                              rob_full;
    logic [ROB_COMPLETE_PORTS-1:0]                     complete_valid;
    logic [ROB_COMPLETE_PORTS-1:0][ROB_DEPTHLOG2-1:0]  complete_slot;
    logic [ROB_COMPLETE_PORTS-1:0][ROB_DATA_W-1:0]     complete_result;
    logic [ROB_RETIRE_WIDTH-1:0]                       retire_valid;
    logic [ROB_RETIRE_WIDTH-1:0][ROB_REG_W-1:0]        retire_dest_reg;
    logic [ROB_RETIRE_WIDTH-1:0]                       retire_dest_valid;
    logic [ROB_RETIRE_WIDTH-1:0][ROB_DATA_W-1:0]       retire_result;

    modport master (
        output flush, reserve, reserve_count, dest_reg, dest_reg_valid,
        output complete_valid, complete_slot, complete_result,
        input  reserved_slots, rob_full,
        input  retire_valid, retire_dest_reg, retire_dest_valid, retire_result
    );

    modport slave (
        input  flush, reserve, reserve_count, dest_reg, dest_reg_valid,
        input  complete_valid, complete_slot, complete_result,
        output reserved_slots, rob_full,
        output retire_valid, retire_dest_reg, retire_dest_valid, retire_result
    );

endinterface

// File: rtl/rob_ctrl.sv
// Reorder buffer: reserves up to 4 slots per cycle, takes 2 out-of-order completions,
// retires up to 2 in order; retire outputs are combinational from registered state.
module rob_ctrl
    import rob_ctrl_pkg::*;
#(
    parameter int ROB_DEPTHLOG2 = 4
) (
    input  logic      clock_i,
    input  logic      reset_i,
    rob_ctrl_if.slave rob_if
);

    localparam int DEPTH = 2 ** ROB_DEPTHLOG2;
    typedef logic [ROB_DEPTHLOG2-1:0] idx_t;
    typedef logic [ROB_DEPTHLOG2:0]   cnt_t;
    localparam cnt_t FULL_THRESH = cnt_t'(DEPTH - ROB_RESERVE_WIDTH);

    idx_t             head_q, head_d;
    idx_t             tail_q, tail_d;
    cnt_t             count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    rob_entry_t       entry_q [DEPTH];
    rob_entry_t       entry_d [DEPTH];

    idx_t head1;
    logic ret0, ret1, rob_full, do_reserve;
    cnt_t n_reserved, n_retired;

    always_comb begin
        rob_full = count_q > FULL_THRESH;
        head1    = head_q + idx_t'(1);
        ret0     = valid_q[head_q] && entry_q[head_q].done;
        ret1     = ret0 && valid_q[head1] && entry_q[head1].done;

        rob_if.rob_full = rob_full;
        for (int i = 0; i < ROB_RESERVE_WIDTH; i++) begin
            rob_if.reserved_slots[i] = tail_q + idx_t'(i);
        end
        rob_if.retire_valid         = {ret1, ret0};
        rob_if.retire_dest_reg[0]   = ret0 ? entry_q[head_q].dest_reg       : '0;
        rob_if.retire_dest_valid[0] = ret0 ? entry_q[head_q].dest_reg_valid : 1'b0;
        rob_if.retire_result[0]     = ret0 ? entry_q[head_q].result         : '0;
        rob_if.retire_dest_reg[1]   = ret1 ? entry_q[head1].dest_reg        : '0;
        rob_if.retire_dest_valid[1] = ret1 ? entry_q[head1].dest_reg_valid  : 1'b0;
        rob_if.retire_result[1]     = ret1 ? entry_q[head1].result          : '0;
    end

    always_comb begin
        valid_d    = valid_q;
        entry_d    = entry_q;
        head_d     = head_q;
        tail_d     = tail_q;
        do_reserve = rob_if.reserve && !rob_full;
        n_reserved = do_reserve ? cnt_t'(rob_if.reserve_count) + cnt_t'(1) : '0;
        n_retired  = cnt_t'(ret0) + cnt_t'(ret1);

        if (do_reserve) begin
            for (int i = 0; i < ROB_RESERVE_WIDTH; i++) begin
                if (2'(i) <= rob_if.reserve_count) begin
                    valid_d[tail_q + idx_t'(i)] = 1'b1;
                    entry_d[tail_q + idx_t'(i)] = '{dest_reg:       rob_if.dest_reg[i],
                                                    dest_reg_valid: rob_if.dest_reg_valid[i],
                                                    done:           1'b0,
                                                    result:         '0};
                end
            end
            tail_d = tail_q + idx_t'(n_reserved);
        end

        // Validity is taken from registered state, so a slot reserved this cycle
        // cannot complete yet. Port 1 is applied first so port 0 wins a shared slot.
        for (int p = ROB_COMPLETE_PORTS - 1; p >= 0; p--) begin
            if (rob_if.complete_valid[p] && valid_q[rob_if.complete_slot[p]]) begin
                entry_d[rob_if.complete_slot[p]].done   = 1'b1;
                entry_d[rob_if.complete_slot[p]].result = rob_if.complete_result[p];
            end
        end

        if (ret0) begin
            valid_d[head_q]      = 1'b0;
            entry_d[head_q].done = 1'b0;
        end
        if (ret1) begin
            valid_d[head1]      = 1'b0;
            entry_d[head1].done = 1'b0;
        end
        head_d  = head_q + idx_t'(n_retired);
        count_d = count_q + n_reserved - n_retired;

        if (rob_if.flush) begin
            valid_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i].done = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            entry_q <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    a_no_reserve_when_full: assert property (
        @(posedge clock_i) disable iff (reset_i) !(rob_if.reserve && rob_full)
    );

endmodule

// File: tb/tb_rob_ctrl.sv
// Randomized bench for rob_ctrl with a program-order queue reference model.
module tb_rob_ctrl;
    import rob_ctrl_pkg::*;

    localparam int LOG2  = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_ctrl_if #(.ROB_DEPTHLOG2(LOG2)) rob_if ();
    rob_ctrl #(.ROB_DEPTHLOG2(LOG2)) dut (.clock_i(clk), .reset_i(rst), .rob_if(rob_if));

    int n_checks = 0;
    int n_errors = 0;

    // Model: in-flight slots in program order plus per-slot payload.
    int          m_q[$];
    int          m_tail = 0;
    bit          m_done [DEPTH];
    logic [4:0]  m_dest [DEPTH];
    logic        m_dv   [DEPTH];
    logic [31:0] m_res  [DEPTH];

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic bit in_rob(int s);
        foreach (m_q[k]) if (m_q[k] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_full();
        return m_q.size() > DEPTH - 4;
    endfunction

    task automatic check_all();
        logic [3:0][LOG2-1:0] es;
        bit r0, r1;
        for (int i = 0; i < 4; i++) es[i] = LOG2'((m_tail + i) % DEPTH);
        check_eq("reserved_slots", 64'(rob_if.reserved_slots), 64'(es));
        check_eq("rob_full", 64'(rob_if.rob_full), 64'(m_full()));
        r0 = 1'b0;
        r1 = 1'b0;
        if (m_q.size() >= 1) r0 = m_done[m_q[0]];
        if (r0 && m_q.size() >= 2) r1 = m_done[m_q[1]];
        check_eq("retire_valid", 64'(rob_if.retire_valid), 64'({r1, r0}));
        if (r0) begin
            check_eq("ret0_dest", 64'(rob_if.retire_dest_reg[0]), 64'(m_dest[m_q[0]]));
            check_eq("ret0_dv", 64'(rob_if.retire_dest_valid[0]), 64'(m_dv[m_q[0]]));
            check_eq("ret0_res", 64'(rob_if.retire_result[0]), 64'(m_res[m_q[0]]));
        end
        if (r1) begin
            check_eq("ret1_dest", 64'(rob_if.retire_dest_reg[1]), 64'(m_dest[m_q[1]]));
            check_eq("ret1_dv", 64'(rob_if.retire_dest_valid[1]), 64'(m_dv[m_q[1]]));
            check_eq("ret1_res", 64'(rob_if.retire_result[1]), 64'(m_res[m_q[1]]));
        end
    endtask

    task automatic model_step();
        bit r0, r1, hit0, hit1, was_full;
        int s0, s1, rc, s;
        if (rst || rob_if.flush) begin
            m_q.delete();
            m_tail = 0;
            return;
        end
        was_full = m_full();
        r0 = 1'b0;
        r1 = 1'b0;
        if (m_q.size() >= 1) r0 = m_done[m_q[0]];
        if (r0 && m_q.size() >= 2) r1 = m_done[m_q[1]];
        s0   = int'(rob_if.complete_slot[0]);
        s1   = int'(rob_if.complete_slot[1]);
        hit0 = rob_if.complete_valid[0] && in_rob(s0);
        hit1 = rob_if.complete_valid[1] && in_rob(s1) && !(hit0 && s1 == s0);
        if (hit0) begin m_done[s0] = 1'b1; m_res[s0] = rob_if.complete_result[0]; end
        if (hit1) begin m_done[s1] = 1'b1; m_res[s1] = rob_if.complete_result[1]; end
        if (r0) void'(m_q.pop_front());
        if (r1) void'(m_q.pop_front());
        if (rob_if.reserve && !was_full) begin
            rc = int'(rob_if.reserve_count);
            for (int i = 0; i <= rc; i++) begin
                s = (m_tail + i) % DEPTH;
                m_q.push_back(s);
                m_done[s] = 1'b0;
                m_dest[s] = rob_if.dest_reg[i];
                m_dv[s]   = rob_if.dest_reg_valid[i];
                m_res[s]  = '0;
            end
            m_tail = (m_tail + rc + 1) % DEPTH;
        end
    endtask

    task automatic set_idle();
        rst                    = 1'b0;
        rob_if.flush           = 1'b0;
        rob_if.reserve         = 1'b0;
        rob_if.reserve_count   = '0;
        rob_if.dest_reg        = '0;
        rob_if.dest_reg_valid  = '0;
        rob_if.complete_valid  = '0;
        rob_if.complete_slot   = '0;
        rob_if.complete_result = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
        set_idle();
    endtask

    task automatic reserve_n(int n, int base);
        rob_if.reserve       = 1'b1;
        rob_if.reserve_count = 2'(n - 1);
        for (int i = 0; i < 4; i++) begin
            rob_if.dest_reg[i]       = 5'(base + i);
            rob_if.dest_reg_valid[i] = 1'b1;
        end
        tick();
    endtask

    task automatic complete1(int slot, logic [31:0] v);
        rob_if.complete_valid     = 2'b01;
        rob_if.complete_slot[0]   = LOG2'(slot);
        rob_if.complete_result[0] = v;
        tick();
    endtask

    task automatic drain();
        int k;
        for (int guard = 0; guard < 100 && m_q.size() > 0; guard++) begin
            k = 0;
            for (int j = 0; j < m_q.size() && k < 2; j++) begin
                if (!m_done[m_q[j]]) begin
                    rob_if.complete_valid[k]  = 1'b1;
                    rob_if.complete_slot[k]   = LOG2'(m_q[j]);
                    rob_if.complete_result[k] = $urandom;
                    k++;
                end
            end
            tick();
        end
    endtask

    task automatic flush_now();
        rob_if.flush = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        tick();
        check_eq("rst_slots", 64'(rob_if.reserved_slots), 64'h3210);
        check_eq("rst_full", 64'(rob_if.rob_full), 64'h0);
        check_eq("rst_rv", 64'(rob_if.retire_valid), 64'h0);
        check_eq("rst_rdest", 64'(rob_if.retire_dest_reg), 64'h0);
        check_eq("rst_rres", 64'(rob_if.retire_result), 64'h0);
        tick();

        // Basic reserve, out-of-order completion, paired retire.
        reserve_n(4, 1);
        check_eq("res_slot0", 64'(rob_if.reserved_slots[0]), 64'd4);
        check_eq("res_slot3", 64'(rob_if.reserved_slots[3]), 64'd7);
        complete1(1, 32'hA);
        check_eq("ooo_wait", 64'(rob_if.retire_valid), 64'h0);
        complete1(0, 32'hB);
        check_eq("ooo_rv", 64'(rob_if.retire_valid), 64'h3);
        check_eq("ooo_dest0", 64'(rob_if.retire_dest_reg[0]), 64'd1);
        check_eq("ooo_res0", 64'(rob_if.retire_result[0]), 64'hB);
        check_eq("ooo_dest1", 64'(rob_if.retire_dest_reg[1]), 64'd2);
        check_eq("ooo_res1", 64'(rob_if.retire_result[1]), 64'hA);
        drain();
        flush_now();

        // Full threshold and full occupancy with head == tail.
        reserve_n(4, 8);
        reserve_n(4, 12);
        reserve_n(4, 16);
        check_eq("full_at_12", 64'(rob_if.rob_full), 64'h0);
        reserve_n(1, 20);
        check_eq("full_at_13", 64'(rob_if.rob_full), 64'h1);
        complete1(0, 32'h55);
        check_eq("retire_one", 64'(rob_if.retire_valid), 64'h1);
        tick();
        check_eq("full_after_retire", 64'(rob_if.rob_full), 64'h0);
        reserve_n(4, 24);
        check_eq("full_at_16", 64'(rob_if.rob_full), 64'h1);
        check_eq("full16_rv", 64'(rob_if.retire_valid), 64'h0);
        check_eq("full16_tail", 64'(rob_if.reserved_slots[0]), 64'd1);
        drain();
        check_eq("drained_full", 64'(rob_if.rob_full), 64'h0);
        flush_now();

        // Wrap-around at the top of the array.
        reserve_n(4, 1);
        reserve_n(4, 5);
        reserve_n(4, 9);
        reserve_n(2, 13);
        drain();
        check_eq("wrap_slots", 64'(rob_if.reserved_slots), 64'h10FE);
        reserve_n(4, 1);
        rob_if.complete_valid  = 2'b11;
        rob_if.complete_slot   = {4'd0, 4'd15};
        rob_if.complete_result = {32'h100, 32'h150};
        tick();
        check_eq("wrap_wait", 64'(rob_if.retire_valid), 64'h0);
        complete1(14, 32'h140);
        check_eq("wrap_lanes", 64'(rob_if.retire_valid), 64'h3);
        check_eq("wrap_res1", 64'(rob_if.retire_result[1]), 64'h150);
        tick();
        check_eq("wrap_slot0", 64'(rob_if.retire_valid), 64'h1);
        check_eq("wrap_res0", 64'(rob_if.retire_result[0]), 64'h100);
        complete1(1, 32'h101);
        drain();
        flush_now();

        // Same-slot dual completion, stray completion, completion racing reservation.
        reserve_n(4, 16);
        rob_if.complete_valid  = 2'b11;
        rob_if.complete_slot   = {4'd3, 4'd3};
        rob_if.complete_result = {32'h22, 32'h11};
        tick();
        rob_if.complete_valid  = 2'b11;
        rob_if.complete_slot   = {4'd1, 4'd0};
        rob_if.complete_result = {32'h1, 32'h0};
        tick();
        complete1(2, 32'h2);
        check_eq("dual_rv", 64'(rob_if.retire_valid), 64'h3);
        check_eq("dual_port0_wins", 64'(rob_if.retire_result[1]), 64'h11);
        tick();
        complete1(9, 32'hDEAD);
        check_eq("stray_rv", 64'(rob_if.retire_valid), 64'h0);
        rob_if.reserve            = 1'b1;
        rob_if.complete_valid     = 2'b01;
        rob_if.complete_slot[0]   = 4'd4;
        rob_if.complete_result[0] = 32'hBEEF;
        tick();
        tick();
        check_eq("race_ignored", 64'(rob_if.retire_valid), 64'h0);
        drain();

        // Flush beats a concurrent reserve and completion.
        reserve_n(4, 3);
        reserve_n(2, 7);
        rob_if.flush            = 1'b1;
        rob_if.reserve          = 1'b1;
        rob_if.reserve_count    = 2'd3;
        rob_if.complete_valid   = 2'b01;
        rob_if.complete_slot[0] = LOG2'(m_q[0]);
        tick();
        check_eq("flush_slots", 64'(rob_if.reserved_slots), 64'h3210);
        check_eq("flush_full", 64'(rob_if.rob_full), 64'h0);
        check_eq("flush_rv", 64'(rob_if.retire_valid), 64'h0);

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            if (!m_full() && $urandom_range(0, 2) != 0) begin
                rob_if.reserve        = 1'b1;
                rob_if.reserve_count  = 2'($urandom_range(0, 3));
                rob_if.dest_reg       = 20'($urandom);
                rob_if.dest_reg_valid = 4'($urandom);
            end
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 4) != 0) begin
                    rob_if.complete_valid[p] = 1'b1;
                    if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                        rob_if.complete_slot[p] = LOG2'(m_q[$urandom_range(0, m_q.size() - 1)]);
                    else
                        rob_if.complete_slot[p] = LOG2'($urandom);
                    rob_if.complete_result[p] = $urandom;
                end
            end
            if ($urandom_range(0, 7) == 0) rob_if.complete_slot[1] = rob_if.complete_slot[0];
            rob_if.flush = ($urandom_range(0, 63) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
